memory_port_arbiter: RTL and testbench
======================================

// Module: memory_port_arbiter
// PURPOSE
//  Shares one single-ported memory interface (Bundle::MemoryIn/MemoryOut) between the instruction-fetch
//  requester (I) and the load/store requester (D). The core talks to it with MemoryRequest payloads.
//  One transaction in flight at a time; the response is steered back to the requester that issued it.
//  Sits between the fetch/mem stages and the memory model/bus adapter.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive D grants while I waits before I is forced to win (1..15)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  i_req_valid    in   1   I request valid
//  i_req          in   69  I MemoryRequest {addr[31:0],data[31:0],fcn[1:0],typ[2:0]}
//  i_req_ready    out  1   I request accepted this cycle
//  i_res_valid    out  1   I response valid (1-cycle pulse)
//  i_res_data     out  32  I response data
//  d_req_valid    in   1   D request valid
//  d_req          in   69  D MemoryRequest
//  d_req_ready    out  1   D request accepted this cycle
//  d_res_valid    out  1   D response valid (1-cycle pulse)
//  d_res_data     out  32  D response data
//  m_req_valid    out  1   request to memory valid
//  m_req          out  69  request to memory (copy of granted payload)
//  m_req_ready    in   1   memory accepts request
//  m_res_valid    in   1   memory response valid
//  m_res_data     in   32  memory response data
//  busy           out  1   transaction outstanding (state==BUSY)
//  err_spurious   out  1   sticky: m_res_valid seen while not BUSY
// BEHAVIOUR
//  Reset: state=IDLE, lock=0, owner=D, starve_cnt=0, err_spurious=0; all valid/ready outputs 0.
//  Handshake: transfer when valid&&ready on the same edge. Payload is held by requester until ready.
//  FSM IDLE:
//   - Unlocked: select D if d_req_valid && !(i_req_valid && starve_cnt==STARVE_LIMIT); else I if
//     i_req_valid. No request -> m_req_valid=0.
//   - m_req_valid = valid of selected; m_req = selected payload (combinational mux).
//   - x_req_ready = (sel==x) && m_req_ready && m_req_valid; the other ready is 0.
//   - If m_req_valid && !m_req_ready: set lock; the selection is frozen until accept (no switching
//     mid-handshake, even if starvation rule or other valid changes).
//   - On accept: owner<=sel, lock<=0, state<=BUSY.
//  FSM BUSY:
//   - m_req_valid=0, i_req_ready=d_req_ready=0.
//   - On m_res_valid: owner's x_res_valid=1 (same cycle, combinational), x_res_data=m_res_data;
//     state<=IDLE. The next grant is possible in the following cycle (minimum 2 cycles/transaction).
//   - Every request, including writes (fcn==M_XWR), receives exactly one response.
//  res_data of the non-owner: driven with m_res_data; its valid stays 0.
//  starve_cnt (4 bits, saturating at STARVE_LIMIT): updated on accept only:
//   - D accepted while i_req_valid=1 -> +1.
//   - I accepted -> 0.
//   - D accepted while I idle -> unchanged.
//  Spurious response (m_res_valid in IDLE): dropped, no x_res_valid; err_spurious<=1 until reset.
//  Simultaneous: accept and response never coincide (the response requires BUSY). Requester
//   deasserting valid while locked violates the protocol; behaviour is undefined.
//  Reset mid-transaction: returns to IDLE immediately; late memory response -> err_spurious.
// TESTING
//  1 I only: i_req addr=0x100, m_req_ready=1, m_res 0xDEADBEEF after 3 cyc -> i_res_valid pulse,
//     data 0xDEADBEEF, d_res_valid never 1.
//  2 Both valid, starve_cnt=0: D (addr 0x2000) granted first, I granted in the cycle after the D
//     response; starve_cnt 0->1->0.
//  3 Both valid continuously, D re-requests each time: grant order D,D,D,D,I,D... (STARVE_LIMIT=4).
//  4 m_req_ready=0 for 5 cycles with D selected, then I asserts with starve_cnt=LIMIT -> D still
//     granted (lock held), m_req stable all 5 cycles.
//  5 m_res_valid pulse in IDLE -> no res_valid to either side, err_spurious=1 until rst_n low.
//  6 rst_n low while BUSY -> busy=0 and all readies 0 immediately; after release I request served
//     normally.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter sharing one single-ported memory: D-priority with I anti-starvation,
// one outstanding transaction, response steered back to the issuing requester.
`timescale 1ns/1ps
module memory_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic [68:0] i_req,
    output logic        i_req_ready,
    output logic        i_res_valid,
    output logic [31:0] i_res_data,
    input  logic        d_req_valid,
    input  logic [68:0] d_req,
    output logic        d_req_ready,
    output logic        d_res_valid,
    output logic [31:0] d_res_data,
    output logic        m_req_valid,
    output logic [68:0] m_req,
    input  logic        m_req_ready,
    input  logic        m_res_valid,
    input  logic [31:0] m_res_data,
    output logic        busy,
    output logic        err_spurious
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic       SEL_D   = 1'b0;
    localparam logic       SEL_I   = 1'b1;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [0:0] state_q, state_d;
    logic       lock_q, lock_d;
    logic       lock_sel_q, lock_sel_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       err_q, err_d;

    logic       sel;
    logic       starved;
    logic       accept;

    // A stalled handshake freezes the selection so the presented payload cannot change.
    always_comb begin
        starved = i_req_valid && (starve_q == LIMIT);
        if (lock_q)
            sel = lock_sel_q;
        else if (d_req_valid && !starved)
            sel = SEL_D;
        else if (i_req_valid)
            sel = SEL_I;
        else
            sel = SEL_D;
    end

    always_comb begin
        m_req_valid = rst_n && (state_q == ST_IDLE) && ((sel == SEL_I) ? i_req_valid : d_req_valid);
        m_req       = (sel == SEL_I) ? i_req : d_req;
        accept      = m_req_valid && m_req_ready;
        i_req_ready = accept && (sel == SEL_I);
        d_req_ready = accept && (sel == SEL_D);
        busy        = (state_q == ST_BUSY);
        i_res_valid = busy && m_res_valid && (owner_q == SEL_I);
        d_res_valid = busy && m_res_valid && (owner_q == SEL_D);
        i_res_data  = m_res_data;
        d_res_data  = m_res_data;
        err_spurious = err_q;
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        err_d      = err_q | (m_res_valid && (state_q == ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    owner_d = sel;
                    lock_d  = 1'b0;
                    if (sel == SEL_I)
                        starve_d = '0;
                    else if (i_req_valid && (starve_q < LIMIT))
                        starve_d = starve_q + 4'd1;
                end else if (m_req_valid) begin
                    lock_d     = 1'b1;
                    lock_sel_d = sel;
                end
            end
            ST_BUSY: begin
                if (m_res_valid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_D;
            owner_q    <= SEL_D;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed requests, expected grants and responses
// queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_memory_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_res_valid;
    logic [68:0] i_req;
    logic [31:0] i_res_data;
    logic        d_req_valid, d_req_ready, d_res_valid;
    logic [68:0] d_req;
    logic [31:0] d_res_data;
    logic        m_req_valid, m_req_ready, m_res_valid;
    logic [68:0] m_req;
    logic [31:0] m_res_data;
    logic        busy, err_spurious;

    memory_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req(i_req), .i_req_ready(i_req_ready),
        .i_res_valid(i_res_valid), .i_res_data(i_res_data),
        .d_req_valid(d_req_valid), .d_req(d_req), .d_req_ready(d_req_ready),
        .d_res_valid(d_res_valid), .d_res_data(d_res_data),
        .m_req_valid(m_req_valid), .m_req(m_req), .m_req_ready(m_req_ready),
        .m_res_valid(m_res_valid), .m_res_data(m_res_data),
        .busy(busy), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic side; logic [31:0] data; } res_t;   // side: 1=I, 0=D

    logic [68:0] exp_grant[$];
    res_t        exp_res[$];
    logic [68:0] iq[$];
    logic [68:0] dq[$];
    bit          i_en, d_en;
    int          spur_req, spur_ack;
    int          mon_checks, mon_errs, main_checks, main_errs;

    function automatic logic [68:0] mk(input logic [31:0] addr);
        return {addr, ~addr, 2'b00, 3'b010};
    endfunction

    // Memory contents seen by the bench's memory model.
    function automatic logic [31:0] memdata(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEADBEEF : addr + 32'h1111_0000;
    endfunction

    // Memory model: answers each accepted request 3 cycles later; can inject a spurious pulse.
    initial begin
        logic [31:0] a;
        m_res_valid = 1'b0;
        m_res_data  = '0;
        spur_ack    = 0;
        forever begin
            @(negedge clk);
            if (m_req_valid && m_req_ready) begin
                a = m_req[68:37];
                repeat (3) @(posedge clk);
                #1 m_res_valid = 1'b1; m_res_data = memdata(a);
                @(posedge clk);
                #1 m_res_valid = 1'b0;
            end else if (spur_req != spur_ack) begin
                spur_ack = spur_ack + 1;
                @(posedge clk);
                #1 m_res_valid = 1'b1; m_res_data = 32'hBAD0BAD0;
                @(posedge clk);
                #1 m_res_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants memory or returns a response.
    initial begin
        logic [68:0] g;
        res_t        r;
        mon_checks = 0;
        mon_errs   = 0;
        forever begin
            @(negedge clk);
            if (m_req_valid && m_req_ready) begin
                mon_checks++;
                if (exp_grant.size() == 0) begin
                    mon_errs++;
                    $display("FAIL grant_unexpected: got m_req addr=%h, expected no grant", m_req[68:37]);
                end else begin
                    g = exp_grant.pop_front();
                    if (m_req !== g) begin
                        mon_errs++;
                        $display("FAIL grant_order: got addr=%h payload=%h, expected addr=%h payload=%h",
                                 m_req[68:37], m_req, g[68:37], g);
                    end
                end
            end
            if (i_res_valid || d_res_valid) begin
                mon_checks++;
                if (exp_res.size() == 0) begin
                    mon_errs++;
                    $display("FAIL res_unexpected: got i_res_valid=%b d_res_valid=%b, expected none",
                             i_res_valid, d_res_valid);
                end else begin
                    r = exp_res.pop_front();
                    if ((i_res_valid !== r.side) || (d_res_valid !== !r.side) ||
                        ((r.side ? i_res_data : d_res_data) !== r.data)) begin
                        mon_errs++;
                        $display("FAIL res_steer: got i_v=%b d_v=%b i_data=%h d_data=%h, expected side_i=%b data=%h",
                                 i_res_valid, d_res_valid, i_res_data, d_res_data, r.side, r.data);
                    end
                end
                mon_checks++;
                if ((i_res_data !== m_res_data) || (d_res_data !== m_res_data)) begin
                    mon_errs++;
                    $display("FAIL res_data_bcast: got i=%h d=%h, expected %h", i_res_data, d_res_data, m_res_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
        main_checks++;
        if (got !== exp) begin
            main_errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic present();
        d_req_valid = d_en && (dq.size() > 0);
        d_req       = (dq.size() > 0) ? dq[0] : '0;
        i_req_valid = i_en && (iq.size() > 0);
        i_req       = (iq.size() > 0) ? iq[0] : '0;
    endtask

    // Requesters hold each payload until its ready, then move to the next queued one.
    task automatic cycles(input int n);
        logic da, ia;
        present();
        repeat (n) begin
            @(negedge clk);
            da = d_req_valid && d_req_ready;
            ia = i_req_valid && i_req_ready;
            @(posedge clk);
            #1;
            if (da) void'(dq.pop_front());
            if (ia) void'(iq.pop_front());
            present();
        end
    endtask

    task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata);
        iq.push_back(mk(addr));
        exp_grant.push_back(mk(addr));
        exp_res.push_back('{side: 1'b1, data: rdata});
    endtask

    task automatic push_d(input logic [31:0] addr, input logic [31:0] rdata);
        dq.push_back(mk(addr));
        exp_grant.push_back(mk(addr));
        exp_res.push_back('{side: 1'b0, data: rdata});
    endtask

    initial begin
        main_checks = 0;
        main_errs   = 0;
        spur_req    = 0;
        i_en = 1'b1; d_en = 1'b1;
        rst_n = 1'b0;
        m_req_ready = 1'b1;
        i_req_valid = 1'b0; i_req = '0;
        d_req_valid = 1'b0; d_req = '0;
        repeat (2) @(posedge clk);
        #1;
        d_req_valid = 1'b1; d_req = mk(32'h9999);
        #1;
        chk("rst_busy", 69'(busy), 69'd0);
        chk("rst_err", 69'(err_spurious), 69'd0);
        chk("rst_m_req_valid", 69'(m_req_valid), 69'd0);
        chk("rst_d_req_ready", 69'(d_req_ready), 69'd0);
        chk("rst_res_valid", 69'({i_res_valid, d_res_valid}), 69'd0);
        d_req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: I alone
        push_i(32'h100, 32'hDEADBEEF);
        cycles(8);

        // 2: both valid, D wins first, I right after
        push_d(32'h2000, 32'h1111_2000);
        push_i(32'h104,  32'h1111_0104);
        cycles(12);

        // 3: continuous contention, I forced after 4 D grants
        for (int unsigned k = 0; k < 4; k++) push_d(32'h3000 + 4*k, memdata(32'h3000 + 4*k));
        push_i(32'h500, 32'h1111_0500);
        for (int unsigned k = 4; k < 8; k++) push_d(32'h3000 + 4*k, memdata(32'h3000 + 4*k));
        push_i(32'h504, 32'h1111_0504);
        push_d(32'h3020, 32'h1111_3020);
        cycles(60);

        // 4: reach starve limit, I withdraws, then stalled D grant must hold against I
        for (int unsigned k = 0; k < 4; k++) push_d(32'h4000 + 4*k, memdata(32'h4000 + 4*k));
        iq.push_back(mk(32'h600));
        cycles(13);
        i_en = 1'b0;
        cycles(4);
        m_req_ready = 1'b0;
        push_d(32'h4010, 32'h1111_4010);
        exp_grant.push_back(mk(32'h600));
        exp_res.push_back('{side: 1'b1, data: 32'h1111_0600});
        present();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lock_m_req", m_req, mk(32'h4010));
            chk("lock_m_valid", 69'(m_req_valid), 69'd1);
            @(posedge clk);
            #1;
        end
        i_en = 1'b1;
        present();
        @(negedge clk);
        chk("lock_vs_starved_i", m_req, mk(32'h4010));
        chk("lock_i_ready", 69'(i_req_ready), 69'd0);
        @(posedge clk);
        #1 m_req_ready = 1'b1;
        cycles(12);

        // 5: spurious response
        spur_req = spur_req + 1;
        cycles(4);
        chk("spurious_err_set", 69'(err_spurious), 69'd1);
        cycles(3);
        chk("spurious_err_sticky", 69'(err_spurious), 69'd1);
        rst_n = 1'b0;
        #1;
        chk("spurious_err_cleared", 69'(err_spurious), 69'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 6: reset while BUSY; the late response is spurious, then normal service
        iq.push_back(mk(32'h700));
        exp_grant.push_back(mk(32'h700));
        cycles(1);
        chk("busy_before_rst", 69'(busy), 69'd1);
        d_req_valid = 1'b1; d_req = mk(32'h7777);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 69'(busy), 69'd0);
        chk("midrst_m_valid", 69'(m_req_valid), 69'd0);
        chk("midrst_readies", 69'({i_req_ready, d_req_ready}), 69'd0);
        d_req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(5);
        chk("late_res_err", 69'(err_spurious), 69'd1);
        push_i(32'h704, 32'h1111_0704);
        cycles(8);

        for (int k = 0; k < 40 && (exp_grant.size() + exp_res.size()) > 0; k++) @(posedge clk);
        chk("grants_drained", 69'(exp_grant.size()), 69'd0);
        chk("responses_drained", 69'(exp_res.size()), 69'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 main_checks + mon_checks, main_errs + mon_errs);
        $finish;
    end

endmodule
